// File: rtl/axis_switch_rr_pkg.sv
// Shared definitions for the round-robin AXI-Stream switch: index-width helper
// and the per-master arbitration state encoding.
package axis_switch_pkg;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } sw_state_t;

endpackage

// File: rtl/axis_switch_rr_if.sv
// Stream bundle of the switch: source-side and master-side handshakes.
interface axis_switch_rr_if #(
   parameter int T_DATA_WIDTH = 8,
   parameter int S_DATA_COUNT = 5,
   parameter int M_DATA_COUNT = 3,
   parameter int T_ID___WIDTH = axis_switch_pkg::idx_width(S_DATA_COUNT),
   parameter int T_DEST_WIDTH = axis_switch_pkg::idx_width(M_DATA_COUNT)
);
   logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_tdata;
   logic [S_DATA_COUNT-1:0]              s_tvalid;
   logic [S_DATA_COUNT-1:0]              s_tlast;
   logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_tdest;
   logic [S_DATA_COUNT-1:0]              s_tready;
   logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_tdata;
   logic [M_DATA_COUNT-1:0]              m_tvalid;
   logic [M_DATA_COUNT-1:0]              m_tlast;
   logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_tid;
   logic [M_DATA_COUNT-1:0]              m_tready;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, s_tdest, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, s_tdest, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
   );
endinterface

// File: rtl/axis_switch_rr_arbiter.sv
// Round-robin arbiter for one master port: search starts one past the last
// winner and wraps; the pointer only moves when the caller commits a grant.
module rr_arbiter
   import axis_switch_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_update,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_grant_idx,
   output logic          o_any
);
   logic [IW-1:0] r_ptr;
   logic [N-1:0]  w_grant;
   logic [IW-1:0] w_idx;
   logic          w_found;

   // Sources at or above the pointer win first, then the wrapped-around ones.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (!w_found && i_req[c] && (c >= int'(r_ptr))) begin
            w_found    = 1'b1;
            w_idx      = IW'(c);
            w_grant[c] = 1'b1;
         end
      end
      for (int c = 0; c < N; c++) begin
         if (!w_found && i_req[c] && (c < int'(r_ptr))) begin
            w_found    = 1'b1;
            w_idx      = IW'(c);
            w_grant[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_update && w_found) begin
         r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
      end
   end

   assign o_grant     = w_grant;
   assign o_grant_idx = w_idx;
   assign o_any       = w_found;
endmodule

// File: rtl/axis_switch_rr.sv
// Packet-aware AXI-Stream switch: per-master round-robin arbitration locked
// for a whole packet, registered master outputs, discard path for bad tdest.
module axis_switch_rr
   import axis_switch_pkg::*;
#(
   parameter int T_DATA_WIDTH = 8,
   parameter int S_DATA_COUNT = 5,
   parameter int M_DATA_COUNT = 3,
   parameter int T_ID___WIDTH = idx_width(S_DATA_COUNT),
   parameter int T_DEST_WIDTH = idx_width(M_DATA_COUNT)
) (
   input logic             clk,
   input logic             rst,
   axis_switch_rr_if.slave sw
);
   localparam int DW = T_DATA_WIDTH;
   localparam int S  = S_DATA_COUNT;
   localparam int M  = M_DATA_COUNT;
   localparam int IW = T_ID___WIDTH;
   localparam int TW = T_DEST_WIDTH;

   sw_state_t       r_state     [M];
   sw_state_t       w_state_nxt [M];
   logic [IW-1:0]   r_grant     [M];
   logic [S-1:0]    r_grant_oh  [M];
   logic [S-1:0]    w_req       [M];
   logic [S-1:0]    w_arb_oh    [M];
   logic [IW-1:0]   w_arb_idx   [M];
   logic [M-1:0]    w_arb_any, w_arb_upd, w_busy, w_free, w_accept, w_sel_last;
   logic [S-1:0]    w_held, w_dest_bad, w_s_tready, r_sink;
   logic [M-1:0]    r_m_tvalid, r_m_tlast;
   logic [DW*M-1:0] r_m_tdata;
   logic [IW*M-1:0] r_m_tid;

   // A source may be claimed only while no master or discard path owns it.
   always_comb begin
      w_held = '0;
      for (int j = 0; j < M; j++) begin
         w_held = w_held | ((r_state[j] == ST_BUSY) ? r_grant_oh[j] : '0);
      end
      for (int j = 0; j < M; j++) begin
         w_req[j] = '0;
         for (int i = 0; i < S; i++) begin
            w_req[j][i] = sw.s_tvalid[i] && (sw.s_tdest[i*TW +: TW] == TW'(j))
                          && !w_held[i] && !r_sink[i];
         end
      end
      for (int i = 0; i < S; i++) begin
         w_dest_bad[i] = (int'(sw.s_tdest[i*TW +: TW]) >= M);
      end
   end

   for (genvar j = 0; j < M; j++) begin : g_arb
      rr_arbiter #(.N(S), .IW(IW)) u_arb (
         .clk         (clk),
         .rst         (rst),
         .i_req       (w_req[j]),
         .i_update    (w_arb_upd[j]),
         .o_grant     (w_arb_oh[j]),
         .o_grant_idx (w_arb_idx[j]),
         .o_any       (w_arb_any[j])
      );
   end

   always_comb begin
      w_s_tready = r_sink;
      for (int j = 0; j < M; j++) begin
         w_busy[j]     = (r_state[j] == ST_BUSY);
         w_free[j]     = !r_m_tvalid[j] || sw.m_tready[j];
         w_sel_last[j] = sw.s_tlast[r_grant[j]];
         w_accept[j]   = w_busy[j] && w_free[j] && sw.s_tvalid[r_grant[j]];
         w_s_tready    = w_s_tready | ((w_busy[j] && w_free[j]) ? r_grant_oh[j] : '0);
      end
   end

   always_comb begin
      for (int j = 0; j < M; j++) begin
         w_state_nxt[j] = r_state[j];
         w_arb_upd[j]   = 1'b0;
         case (r_state[j])
            ST_IDLE: begin
               if (w_arb_any[j]) begin
                  w_state_nxt[j] = ST_BUSY;
                  w_arb_upd[j]   = 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_accept[j] && w_sel_last[j]) begin
                  w_state_nxt[j] = ST_IDLE;
               end
            end
            default: w_state_nxt[j] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < M; j++) begin
         r_state[j] <= rst ? ST_IDLE : w_state_nxt[j];
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < M; j++) begin
         if (rst) begin
            r_grant[j]    <= '0;
            r_grant_oh[j] <= '0;
         end else if (w_arb_upd[j]) begin
            r_grant[j]    <= w_arb_idx[j];
            r_grant_oh[j] <= w_arb_oh[j];
         end
      end
   end

   // Bad-destination packets are swallowed beat by beat until their tlast.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sink <= '0;
      end else begin
         for (int i = 0; i < S; i++) begin
            if (r_sink[i]) begin
               if (sw.s_tvalid[i] && sw.s_tlast[i]) r_sink[i] <= 1'b0;
            end else if (sw.s_tvalid[i] && w_dest_bad[i] && !w_held[i]) begin
               r_sink[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_tvalid <= '0;
         r_m_tlast  <= '0;
         r_m_tdata  <= '0;
         r_m_tid    <= '0;
      end else begin
         for (int j = 0; j < M; j++) begin
            if (w_accept[j]) begin
               r_m_tvalid[j]            <= 1'b1;
               r_m_tlast[j]             <= w_sel_last[j];
               r_m_tdata[j*DW +: DW]    <= sw.s_tdata[int'(r_grant[j])*DW +: DW];
               r_m_tid[j*IW +: IW]      <= r_grant[j];
            end else if (sw.m_tready[j]) begin
               r_m_tvalid[j] <= 1'b0;
            end
         end
      end
   end

   assign sw.s_tready = w_s_tready;
   assign sw.m_tvalid = r_m_tvalid;
   assign sw.m_tlast  = r_m_tlast;
   assign sw.m_tdata  = r_m_tdata;
   assign sw.m_tid    = r_m_tid;
endmodule

// File: doc/axis_switch_rr.md
# axis_switch_rr

Packet-aware AXI-Stream switch connecting S_DATA_COUNT source ports to M_DATA_COUNT master ports. Each beat is routed by s_tdest; each master port has its own round-robin arbiter that locks onto one source for a whole packet, up to tlast. Master outputs are registered with full valid/ready backpressure. The block sits between stream producers and consumers in the streaming fabric and replaces externally supplied static grant vectors with internal arbitration.

## Interface
- T_DATA_WIDTH, 8, payload width per port
- S_DATA_COUNT, 5, number of source ports (≥2)
- M_DATA_COUNT, 3, number of master ports (≥2)
- T_ID___WIDTH, $clog2(S_DATA_COUNT), source-index width
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), destination-index width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_tdata  in  T_DATA_WIDTH*S_DATA_COUNT  source payloads, port i at [i*T_DATA_WIDTH +: T_DATA_WIDTH]
- s_tvalid  in  S_DATA_COUNT  source valid
- s_tlast  in  S_DATA_COUNT  source end of packet
- s_tdest  in  T_DEST_WIDTH*S_DATA_COUNT  destination master index per source
- s_tready  out  S_DATA_COUNT  source ready
- m_tdata  out  T_DATA_WIDTH*M_DATA_COUNT  master payloads
- m_tvalid  out  M_DATA_COUNT  master valid
- m_tlast  out  M_DATA_COUNT  master end of packet
- m_tid  out  T_ID___WIDTH*M_DATA_COUNT  index of the source that produced the beat
- m_tready  in  M_DATA_COUNT  master ready

## Operation
- Source i requests master j when s_tvalid[i]=1 and s_tdest[i]=j.
- Each master runs a 2-state FSM:
  - IDLE: if any request is present, the round-robin winner is registered as the grant, and the FSM moves to BUSY.
  - BUSY: beats transfer from the granted source. When the granted source's tlast beat is accepted, the FSM returns to IDLE.
- Round-robin priority: search starts at last_grant+1 and wraps modulo S_DATA_COUNT. After reset, the search starts at source 0.
- s_tready[i] = 1 only when source i is granted by master j in BUSY and master j's output slot is free, where free means !m_tvalid[j] || m_tready[j].
- A source is granted by at most one master at a time. s_tdest is latched at grant and ignored for the rest of the packet. Changing s_tdest mid-packet has no effect.
- Invalid destination (s_tdest ≥ M_DATA_COUNT): the source is sink-granted. s_tready=1 and beats are discarded until its tlast.
- Output register: on acceptance, m_tdata/m_tlast/m_tid load from the source and m_tvalid is set. m_tvalid clears on m_tready when no new beat is loaded.
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0, s_tready=0, all FSMs IDLE, grants cleared, RR pointers 0. Reset mid-packet drops the in-flight packet with no partial flush.

## Timing
- Request first visible in cycle N (master in IDLE) → BUSY with grant in N+1. s_tready is high in N+1 if the slot is free. The beat is on m_* in N+2.
- Throughput in BUSY is 1 beat/clk with m_tready held high.
- The tlast beat is accepted in cycle K → IDLE in K+1 → next grant in K+2. This gives exactly one idle arbitration cycle between packets on a port.
- m_tready low: the output beat holds stable, s_tready of the granted source drops in the same cycle, and no beat is lost or duplicated.
- Different masters arbitrate and transfer independently in the same cycle.

## Structure
- Package axis_switch_pkg holds the index-width helper functions and the FSM state encoding (IDLE=0, BUSY=1).
- Sub-module rr_arbiter holds one request vector, the rotating pointer, and a one-hot grant output. Instantiate it M_DATA_COUNT times.
- The top level contains the per-master FSMs, grant registers, source-ready OR-reduction, data muxes and output registers.

## Test plan
- Single packet: source 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), tdest=1, m_tready=1 → m_tdata[1] shows A1,A2,A3 on cycles N+2..N+4, m_tlast only on A3, m_tid=2.
- Contention: sources 0, 1 and 4 each send a 2-beat packet to master 0 simultaneously → grant order 0,1,4, one idle cycle between packets, no interleaving.
- Backpressure: m_tready[2] toggles 1,0,0,1 during a 4-beat packet → all 4 beats are delivered in order, and s_tready deasserts in the same cycles that m_tready is low with the slot full.
- Parallel routes: source 0→master 2 and source 3→master 0 concurrently, 8 beats each → both complete in 8 beats + 2 cycles latency with no cross-talk.
- Invalid dest: source 1 sends tdest=3 (with M_DATA_COUNT=3), 2 beats → s_tready=1 and no m_tvalid on any port.
- Reset mid-packet: assert rst after beat 2 of 4 → all outputs at reset values next cycle, and the next packet from source 0 wins arbitration first.
